// File: rtl/otter_pkg.sv
// Shared OTTER definitions: ALU function codes, branch opcodes/funct3 and execute-stage states.
package otter_pkg;

    typedef enum logic [3:0] {
        AluAdd  = 4'b0000,
        AluSll  = 4'b0001,
        AluSlt  = 4'b0010,
        AluSltu = 4'b0011,
        AluXor  = 4'b0100,
        AluSrl  = 4'b0101,
        AluOr   = 4'b0110,
        AluAnd  = 4'b0111,
        AluSub  = 4'b1000,
        AluLui  = 4'b1001,
        AluSra  = 4'b1101
    } alu_fun_t;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        Run    = 1'b0,
        Squash = 1'b1
    } ex_state_t;

endpackage

// File: rtl/otter_alu.sv
// Combinational OTTER ALU: RESULT = A op B, unknown function codes give 0.
module otter_alu
    import otter_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ALU_FUN,
    output logic [31:0] RESULT
);

    logic [4:0] shamt;
    assign shamt = B[4:0];

    always_comb begin
        RESULT = 32'd0;
        case (ALU_FUN)
            AluAdd:  RESULT = A + B;
            AluSub:  RESULT = A - B;
            AluSll:  RESULT = A << shamt;
            AluSlt:  RESULT = {31'd0, $signed(A) < $signed(B)};
            AluSltu: RESULT = {31'd0, A < B};
            AluXor:  RESULT = A ^ B;
            AluSrl:  RESULT = A >> shamt;
            AluSra:  RESULT = $unsigned($signed(A) >>> shamt);
            AluOr:   RESULT = A | B;
            AluAnd:  RESULT = A & B;
            AluLui:  RESULT = A;
            default: RESULT = 32'd0;
        endcase
    end

endmodule

// File: rtl/execute_state.sv
// OTTER execute stage: ALU, branch resolution, redirect/squash FSM and execute pipeline register.
// Optional EX_PERF_CNT_EN adds retired/squashed instruction counters.
module execute_state
    import otter_pkg::*;
#(
    parameter int unsigned SQUASH_SLOTS = 2
) (
    input  logic        REG_CLOCK,
    input  logic        REG_RESET_N,
    input  logic        DEC_VALID,
    input  logic [31:0] DEC_PC,
    input  logic [31:0] DEC_PC_OUT,
    input  logic [31:0] DEC_ALU_A,
    input  logic [31:0] DEC_ALU_B,
    input  logic [31:0] DEC_RS1,
    input  logic [31:0] DEC_RS2,
    input  logic [31:0] DEC_J_TYPE,
    input  logic [31:0] DEC_B_TYPE,
    input  logic [31:0] DEC_I_TYPE,
    input  logic [31:0] DEC_MEM_IR,
    input  logic [3:0]  DEC_ALU_FUN,
    input  logic        DEC_REGWRITE,
    input  logic        DEC_MEMWRITE,
    input  logic        DEC_MEMREAD_2,
    input  logic [1:0]  DEC_RF_WR_SEL,
    input  logic        EX_STALL,
    output logic        DEC_READY,
    output logic        EX_VALID,
    output logic [31:0] EX_ALU_RESULT,
    output logic [31:0] EX_RS2,
    output logic [31:0] EX_MEM_IR,
    output logic [31:0] EX_PC_4,
    output logic        EX_REGWRITE,
    output logic        EX_MEMWRITE,
    output logic        EX_MEMREAD_2,
    output logic [1:0]  EX_RF_WR_SEL,
    output logic        EX_REDIRECT,
`ifdef EX_PERF_CNT_EN
    output logic [31:0] EX_CNT_RETIRED,
    output logic [31:0] EX_CNT_SQUASHED,
`endif
    output logic [31:0] EX_REDIRECT_PC
);

    ex_state_t   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        capture, live, taken, kill;
    logic [31:0] target, alu_result;
    logic [6:0]  opcode;
    logic [2:0]  funct3;

    assign DEC_READY = ~EX_STALL;
    assign capture   = ~EX_STALL;
    assign live      = DEC_VALID && (state_q == Run);
    assign opcode    = DEC_MEM_IR[6:0];
    assign funct3    = DEC_MEM_IR[14:12];

    otter_alu u_alu (
        .A       (DEC_ALU_A),
        .B       (DEC_ALU_B),
        .ALU_FUN (DEC_ALU_FUN),
        .RESULT  (alu_result)
    );

    always_comb begin
        taken  = 1'b0;
        target = 32'd0;
        case (opcode)
            OPC_JAL: begin
                taken  = 1'b1;
                target = DEC_PC + DEC_J_TYPE;
            end
            OPC_JALR: begin
                taken  = 1'b1;
                target = (DEC_RS1 + DEC_I_TYPE) & ~32'd1;
            end
            OPC_BRANCH: begin
                target = DEC_PC + DEC_B_TYPE;
                case (funct3)
                    F3_BEQ:  taken = DEC_RS1 == DEC_RS2;
                    F3_BNE:  taken = DEC_RS1 != DEC_RS2;
                    F3_BLT:  taken = $signed(DEC_RS1) < $signed(DEC_RS2);
                    F3_BGE:  taken = $signed(DEC_RS1) >= $signed(DEC_RS2);
                    F3_BLTU: taken = DEC_RS1 < DEC_RS2;
                    F3_BGEU: taken = DEC_RS1 >= DEC_RS2;
                    default: taken = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    // Invalid decode slots during SQUASH pass through without consuming the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kill    = 1'b0;
        case (state_q)
            Run: begin
                if (capture && live && taken) begin
                    state_d = Squash;
                    cnt_d   = 2'(SQUASH_SLOTS);
                end
            end
            Squash: begin
                if (capture && DEC_VALID) begin
                    kill  = 1'b1;
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_d = Run;
                    end
                end
            end
            default: state_d = Run;
        endcase
    end

    always_ff @(posedge REG_CLOCK or negedge REG_RESET_N) begin
        if (!REG_RESET_N) begin
            state_q <= Run;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge REG_CLOCK or negedge REG_RESET_N) begin
        if (!REG_RESET_N) begin
            EX_VALID       <= 1'b0;
            EX_ALU_RESULT  <= 32'd0;
            EX_RS2         <= 32'd0;
            EX_MEM_IR      <= 32'd0;
            EX_PC_4        <= 32'd0;
            EX_REGWRITE    <= 1'b0;
            EX_MEMWRITE    <= 1'b0;
            EX_MEMREAD_2   <= 1'b0;
            EX_RF_WR_SEL   <= 2'd0;
            EX_REDIRECT    <= 1'b0;
            EX_REDIRECT_PC <= 32'd0;
        end else begin
            EX_REDIRECT <= 1'b0;
            if (capture) begin
                EX_VALID      <= live;
                EX_ALU_RESULT <= alu_result;
                EX_RS2        <= DEC_RS2;
                EX_MEM_IR     <= DEC_MEM_IR;
                EX_PC_4       <= DEC_PC_OUT;
                EX_REGWRITE   <= DEC_REGWRITE & live;
                EX_MEMWRITE   <= DEC_MEMWRITE & live;
                EX_MEMREAD_2  <= DEC_MEMREAD_2 & live;
                EX_RF_WR_SEL  <= DEC_RF_WR_SEL;
                if (live && taken) begin
                    EX_REDIRECT    <= 1'b1;
                    EX_REDIRECT_PC <= target;
                end
            end
        end
    end

`ifdef EX_PERF_CNT_EN
    always_ff @(posedge REG_CLOCK or negedge REG_RESET_N) begin
        if (!REG_RESET_N) begin
            EX_CNT_RETIRED  <= 32'd0;
            EX_CNT_SQUASHED <= 32'd0;
        end else begin
            if (capture && live) begin
                EX_CNT_RETIRED <= EX_CNT_RETIRED + 32'd1;
            end
            if (kill) begin
                EX_CNT_SQUASHED <= EX_CNT_SQUASHED + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_execute_state.sv
// Self-checking bench for execute_state: directed scenarios followed by randomized traffic
// checked against a behavioural model of the execute stage.
module tb_execute_state;

    localparam int unsigned SLOTS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid, ex_stall;
    logic [31:0] dec_pc, dec_pc_out, dec_alu_a, dec_alu_b, dec_rs1, dec_rs2;
    logic [31:0] dec_j_type, dec_b_type, dec_i_type, dec_mem_ir;
    logic [3:0]  dec_alu_fun;
    logic        dec_regwrite, dec_memwrite, dec_memread_2;
    logic [1:0]  dec_rf_wr_sel;

    logic        dec_ready, ex_valid, ex_regwrite, ex_memwrite, ex_memread_2, ex_redirect;
    logic [31:0] ex_alu_result, ex_rs2, ex_mem_ir, ex_pc_4, ex_redirect_pc;
    logic [1:0]  ex_rf_wr_sel;
`ifdef EX_PERF_CNT_EN
    logic [31:0] ex_cnt_retired, ex_cnt_squashed;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int          m_left;
    bit          m_valid, m_rw, m_mw, m_mr, m_redir;
    logic [31:0] m_alu, m_rs2, m_ir, m_pc4, m_rpc;
    logic [1:0]  m_sel;
    logic [31:0] m_ret, m_sq;

    always #5 clk = ~clk;

    execute_state #(.SQUASH_SLOTS(SLOTS)) dut (
        .REG_CLOCK      (clk),
        .REG_RESET_N    (rst_n),
        .DEC_VALID      (dec_valid),
        .DEC_PC         (dec_pc),
        .DEC_PC_OUT     (dec_pc_out),
        .DEC_ALU_A      (dec_alu_a),
        .DEC_ALU_B      (dec_alu_b),
        .DEC_RS1        (dec_rs1),
        .DEC_RS2        (dec_rs2),
        .DEC_J_TYPE     (dec_j_type),
        .DEC_B_TYPE     (dec_b_type),
        .DEC_I_TYPE     (dec_i_type),
        .DEC_MEM_IR     (dec_mem_ir),
        .DEC_ALU_FUN    (dec_alu_fun),
        .DEC_REGWRITE   (dec_regwrite),
        .DEC_MEMWRITE   (dec_memwrite),
        .DEC_MEMREAD_2  (dec_memread_2),
        .DEC_RF_WR_SEL  (dec_rf_wr_sel),
        .EX_STALL       (ex_stall),
        .DEC_READY      (dec_ready),
        .EX_VALID       (ex_valid),
        .EX_ALU_RESULT  (ex_alu_result),
        .EX_RS2         (ex_rs2),
        .EX_MEM_IR      (ex_mem_ir),
        .EX_PC_4        (ex_pc_4),
        .EX_REGWRITE    (ex_regwrite),
        .EX_MEMWRITE    (ex_memwrite),
        .EX_MEMREAD_2   (ex_memread_2),
        .EX_RF_WR_SEL   (ex_rf_wr_sel),
        .EX_REDIRECT    (ex_redirect),
`ifdef EX_PERF_CNT_EN
        .EX_CNT_RETIRED (ex_cnt_retired),
        .EX_CNT_SQUASHED(ex_cnt_squashed),
`endif
        .EX_REDIRECT_PC (ex_redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] f);
        int unsigned sh;
        sh = int'(b[4:0]);
        case (f)
            4'h0: return a + b;
            4'h8: return a - b;
            4'h1: return a << sh;
            4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h3: return (a < b) ? 32'd1 : 32'd0;
            4'h4: return a ^ b;
            4'h5: return a >> sh;
            4'hD: return $unsigned($signed(a) >>> sh);
            4'h6: return a | b;
            4'h7: return a & b;
            4'h9: return a;
            default: return 32'd0;
        endcase
    endfunction

    task automatic branch_ref(output bit tk, output logic [31:0] tg);
        logic signed [31:0] s1, s2;
        s1 = dec_rs1;
        s2 = dec_rs2;
        tk = 1'b0;
        tg = 32'd0;
        if (dec_mem_ir[6:0] == 7'h6F) begin
            tk = 1'b1;
            tg = dec_pc + dec_j_type;
        end else if (dec_mem_ir[6:0] == 7'h67) begin
            tk = 1'b1;
            tg = (dec_rs1 + dec_i_type) & 32'hFFFF_FFFE;
        end else if (dec_mem_ir[6:0] == 7'h63) begin
            tg = dec_pc + dec_b_type;
            case (dec_mem_ir[14:12])
                3'd0: tk = (dec_rs1 == dec_rs2);
                3'd1: tk = (dec_rs1 != dec_rs2);
                3'd4: tk = (s1 < s2);
                3'd5: tk = (s1 >= s2);
                3'd6: tk = (dec_rs1 < dec_rs2);
                3'd7: tk = (dec_rs1 >= dec_rs2);
                default: tk = 1'b0;
            endcase
        end
    endtask

    task automatic model_reset();
        m_left = 0;
        {m_valid, m_rw, m_mw, m_mr, m_redir} = '0;
        {m_alu, m_rs2, m_ir, m_pc4, m_rpc} = '0;
        m_sel = 2'd0;
        m_ret = 32'd0;
        m_sq  = 32'd0;
    endtask

    task automatic model_edge();
        bit          tk, live;
        logic [31:0] tg;
        branch_ref(tk, tg);
        if (!ex_stall) begin
            live    = dec_valid && (m_left == 0);
            m_valid = live;
            m_alu   = alu_ref(dec_alu_a, dec_alu_b, dec_alu_fun);
            m_rs2   = dec_rs2;
            m_ir    = dec_mem_ir;
            m_pc4   = dec_pc_out;
            m_rw    = dec_regwrite && live;
            m_mw    = dec_memwrite && live;
            m_mr    = dec_memread_2 && live;
            m_sel   = dec_rf_wr_sel;
            m_redir = live && tk;
            if (live && tk) begin
                m_rpc  = tg;
                m_left = SLOTS;
            end else if (m_left > 0 && dec_valid) begin
                m_left--;
                m_sq++;
            end
            if (live) m_ret++;
        end else begin
            m_redir = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("ready", {31'd0, dec_ready}, {31'd0, ~ex_stall});
        chk("valid", {31'd0, ex_valid}, {31'd0, m_valid});
        chk("alu_result", ex_alu_result, m_alu);
        chk("rs2", ex_rs2, m_rs2);
        chk("mem_ir", ex_mem_ir, m_ir);
        chk("pc_4", ex_pc_4, m_pc4);
        chk("regwrite", {31'd0, ex_regwrite}, {31'd0, m_rw});
        chk("memwrite", {31'd0, ex_memwrite}, {31'd0, m_mw});
        chk("memread_2", {31'd0, ex_memread_2}, {31'd0, m_mr});
        chk("rf_wr_sel", {30'd0, ex_rf_wr_sel}, {30'd0, m_sel});
        chk("redirect", {31'd0, ex_redirect}, {31'd0, m_redir});
        chk("redirect_pc", ex_redirect_pc, m_rpc);
`ifdef EX_PERF_CNT_EN
        chk("cnt_retired", ex_cnt_retired, m_ret);
        chk("cnt_squashed", ex_cnt_squashed, m_sq);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_plain(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        dec_valid     = 1'b1;
        dec_alu_a     = a;
        dec_alu_b     = b;
        dec_alu_fun   = f;
        dec_mem_ir    = 32'h0000_0033;
        dec_regwrite  = 1'b1;
        dec_memwrite  = 1'b1;
        dec_memread_2 = 1'b0;
        dec_rf_wr_sel = 2'd3;
        dec_pc        = 32'h0000_0080;
        dec_pc_out    = 32'h0000_0084;
    endtask

    task automatic randomize_inputs();
        logic [6:0] opcs [6];
        opcs = '{7'h6F, 7'h67, 7'h63, 7'h63, 7'h33, 7'h23};
        dec_valid     = ($urandom_range(0, 9) < 8);
        ex_stall      = ($urandom_range(0, 3) == 0);
        dec_pc        = $urandom & 32'hFFFF_FFFC;
        dec_pc_out    = dec_pc + 32'd4;
        dec_alu_a     = $urandom;
        dec_alu_b     = $urandom;
        dec_rs1       = $urandom;
        dec_rs2       = ($urandom_range(0, 2) == 0) ? dec_rs1 : $urandom;
        dec_j_type    = $urandom;
        dec_b_type    = $urandom;
        dec_i_type    = $urandom;
        dec_mem_ir    = ($urandom & 32'hFFFF_FF80) | {25'd0, opcs[$urandom_range(0, 5)]};
        dec_alu_fun   = 4'($urandom);
        dec_regwrite  = 1'($urandom);
        dec_memwrite  = 1'($urandom);
        dec_memread_2 = 1'($urandom);
        dec_rf_wr_sel = 2'($urandom);
    endtask

    initial begin
        rst_n     = 1'b0;
        ex_stall  = 1'b0;
        dec_rs1   = 32'd0;
        dec_rs2   = 32'd0;
        dec_j_type = 32'd0;
        dec_b_type = 32'd0;
        dec_i_type = 32'd0;
        set_plain(32'd0, 32'd0, 4'd0);
        dec_valid = 1'b0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // add
        set_plain(32'd5, 32'd7, 4'b0000);
        tick();
        chk("add_result", ex_alu_result, 32'd12);
        chk("add_valid", {31'd0, ex_valid}, 32'd1);

        // sra
        set_plain(32'h8000_0000, 32'd4, 4'b1101);
        tick();
        chk("sra_result", ex_alu_result, 32'hF800_0000);

        // taken beq, then two killed valid slots with a bubble between
        set_plain(32'd1, 32'd1, 4'd0);
        dec_mem_ir = 32'h0000_0063;
        dec_rs1    = 32'd3;
        dec_rs2    = 32'd3;
        dec_pc     = 32'h0000_0100;
        dec_b_type = 32'h0000_0020;
        tick();
        chk("beq_redirect", {31'd0, ex_redirect}, 32'd1);
        chk("beq_target", ex_redirect_pc, 32'h0000_0120);
        set_plain(32'd2, 32'd2, 4'd0);
        dec_mem_ir = 32'h0000_006F;
        tick();
        chk("kill1_valid", {31'd0, ex_valid}, 32'd0);
        chk("kill1_memwrite", {31'd0, ex_memwrite}, 32'd0);
        chk("kill1_redirect", {31'd0, ex_redirect}, 32'd0);
        dec_valid = 1'b0;
        tick();
        set_plain(32'd3, 32'd3, 4'd0);
        tick();
        chk("kill2_valid", {31'd0, ex_valid}, 32'd0);
        chk("kill2_memwrite", {31'd0, ex_memwrite}, 32'd0);
        set_plain(32'd4, 32'd4, 4'd0);
        tick();
        chk("third_live", {31'd0, ex_valid}, 32'd1);

        // jalr clears bit 0 of the target
        set_plain(32'd0, 32'd0, 4'd0);
        dec_mem_ir = 32'h0000_0067;
        dec_rs1    = 32'h0000_0203;
        dec_i_type = 32'd0;
        tick();
        chk("jalr_target", ex_redirect_pc, 32'h0000_0202);
        set_plain(32'd1, 32'd1, 4'd0);
        tick();
        tick();

        // stalled jal: nothing moves until the capture edge
        set_plain(32'd9, 32'd9, 4'd0);
        dec_mem_ir = 32'h0000_006F;
        dec_pc     = 32'h0000_0040;
        dec_j_type = 32'h0000_0010;
        ex_stall   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_redirect", {31'd0, ex_redirect}, 32'd0);
        end
        ex_stall = 1'b0;
        tick();
        chk("jal_redirect", {31'd0, ex_redirect}, 32'd1);
        chk("jal_target", ex_redirect_pc, 32'h0000_0050);
        ex_stall = 1'b1;
        tick();
        chk("redirect_single_pulse", {31'd0, ex_redirect}, 32'd0);
        ex_stall = 1'b0;
        set_plain(32'd1, 32'd1, 4'd0);
        tick();
        tick();

        // reset in the middle of a squash
        set_plain(32'd0, 32'd0, 4'd0);
        dec_mem_ir = 32'h0000_0063;
        dec_rs1    = 32'd3;
        dec_rs2    = 32'd3;
        tick();
        set_plain(32'd6, 32'd6, 4'd0);
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("reset_valid", {31'd0, ex_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_plain(32'd10, 32'd20, 4'd0);
        tick();
        chk("post_reset_live", {31'd0, ex_valid}, 32'd1);
        chk("post_reset_result", ex_alu_result, 32'd30);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
